// File: rtl/seq_detector_param.sv
// Serial pattern detector with overlapping/non-overlapping modes and a saturating match counter.
// The counter is built only when SEQ_DETECTOR_PARAM_COUNT_EN is defined; otherwise match_cnt is tied to 0.
module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             primed
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] next_hist;
  logic [FILL_W-1:0]  fill;
  logic               hit;

  // The incoming bit completes a match only if the older PAT_LEN-1 bits are all valid.
  always_comb begin
    next_hist = {hist[PAT_LEN-2:0], x};
    hit       = en && !clr && (next_hist == PATTERN) && (fill >= FILL_LAST);
  end

  // History, fill and match pulse; a non-overlapping hit restarts fill so no matched bit is reused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist  <= {PAT_LEN{1'b0}};
      fill  <= {FILL_W{1'b0}};
      match <= 1'b0;
    end else if (clr) begin
      hist  <= {PAT_LEN{1'b0}};
      fill  <= {FILL_W{1'b0}};
      match <= 1'b0;
    end else if (en) begin
      hist  <= next_hist;
      match <= hit;
      if (hit && !overlap) begin
        fill <= {FILL_W{1'b0}};
      end else if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end else begin
        fill <= fill;
      end
    end else begin
      match <= 1'b0;
    end
  end

  assign primed = (fill == FILL_FULL);

`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating count of hits; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (hit && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PATTERN=1011), with a CNT_W=2 instance for saturation.
`timescale 1ns/1ps
module tb_seq_detector_param;

`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       overlap = 1'b1;
  logic       clr = 1'b0;
  logic       match_a, primed_a, match_b, primed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int failures = 0;

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr(clr),
    .match(match_a), .match_cnt(cnt_a), .primed(primed_a)
  );

  seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .clr(clr),
    .match(match_b), .match_cnt(cnt_b), .primed(primed_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic xi, input logic ei, input logic oi, input logic ci);
    @(negedge clk);
    x = xi; en = ei; overlap = oi; clr = ci;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt(input int n);
    return CNT_ON * n;
  endfunction

  logic [6:0] stream;
  logic [6:0] hits_ovl;
  logic [6:0] hits_non;

  initial begin
    stream   = 7'b1011011;   // MSB is sent first
    hits_ovl = 7'b0001001;
    hits_non = 7'b0001000;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_match", {31'd0, match_a}, 32'd0);
    check("rst_cnt", {24'd0, cnt_a}, 32'd0);
    check("rst_primed", {31'd0, primed_a}, 32'd0);
    #4 rst = 1'b0;

    // Overlapping detection of 1011011
    for (int i = 6; i >= 0; i--) begin
      step(stream[i], 1'b1, 1'b1, 1'b0);
      check($sformatf("ovl_match_e%0d", 7 - i), {31'd0, match_a}, {31'd0, hits_ovl[i]});
    end
    check("ovl_cnt", {24'd0, cnt_a}, exp_cnt(2));
    check("ovl_primed", {31'd0, primed_a}, 32'd1);

    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_match", {31'd0, match_a}, 32'd0);
    check("clr_cnt", {24'd0, cnt_a}, 32'd0);
    check("clr_primed", {31'd0, primed_a}, 32'd0);

    // Non-overlapping detection of the same stream
    for (int i = 6; i >= 0; i--) begin
      step(stream[i], 1'b1, 1'b0, 1'b0);
      check($sformatf("non_match_e%0d", 7 - i), {31'd0, match_a}, {31'd0, hits_non[i]});
    end
    check("non_cnt", {24'd0, cnt_a}, exp_cnt(1));
    check("non_primed_fill3", {31'd0, primed_a}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("non_primed_fill4", {31'd0, primed_a}, 32'd1);
    check("non_e8_match", {31'd0, match_a}, 32'd0);

    // Enable gaps: x=1 while en=0 must be ignored
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check($sformatf("gap_match_%0d", i), {31'd0, match_a}, 32'd0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("gap_final_match", {31'd0, match_a}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("gap_pulse_end", {31'd0, match_a}, 32'd0);
    check("gap_cnt_hold", {24'd0, cnt_a}, exp_cnt(1));

    // Clear on the edge that would complete 1011
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clrhit_match", {31'd0, match_a}, 32'd0);
    check("clrhit_cnt", {24'd0, cnt_a}, 32'd0);
    check("clrhit_primed", {31'd0, primed_a}, 32'd0);

    // Reset right after a match, away from the clock edge
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("prerst_match", {31'd0, match_a}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_match", {31'd0, match_a}, 32'd0);
    check("arst_cnt", {24'd0, cnt_a}, 32'd0);
    check("arst_primed", {31'd0, primed_a}, 32'd0);
    #1 rst = 1'b0;
    // Without the reset, 0,1,1 would complete an overlapping 1011
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("postrst_match", {31'd0, match_a}, 32'd0);
    check("postrst_primed", {31'd0, primed_a}, 32'd0);

    // Five back-to-back overlapping matches: 1011 then 011 four times
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int m = 0; m < 5; m++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check($sformatf("sat_match_b%0d", m), {31'd0, match_b}, 32'd1);
    end
    check("sat_cnt_b", {30'd0, cnt_b}, exp_cnt(3));
    check("sat_cnt_a", {24'd0, cnt_a}, exp_cnt(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_LEN, default 4, is the pattern length in bits; the legal range SHALL be 2..32.
REQ-002 Parameter PATTERN, default 4'b1011 (PAT_LEN bits wide), is the target sequence; bit PAT_LEN-1 is the oldest bit.
REQ-003 Parameter CNT_W, default 8, is the match counter width; the legal range SHALL be 1..32.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  sample enable; x is consumed only on edges where en=1.
REQ-007 x  input  1  serial data bit.
REQ-008 overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 clr  input  1  synchronous clear of history, fill, match and count.
REQ-010 match  output  1  registered one-cycle pulse per detected pattern.
REQ-011 match_cnt  output  CNT_W  saturating count of detected patterns.
REQ-012 primed  output  1  high when fill equals PAT_LEN, i.e. the history is fully valid.

Function
REQ-013 The block SHALL hold a PAT_LEN-bit history register hist and a fill counter fill (range 0..PAT_LEN).
REQ-014 On an edge with en=1 and clr=0: hist <= {hist[PAT_LEN-2:0], x}; fill <= min(fill+1, PAT_LEN).
REQ-015 hit is defined as: en=1 and clr=0 and {hist[PAT_LEN-2:0], x} == PATTERN and fill >= PAT_LEN-1.
REQ-016 match SHALL be registered: match <= hit on every edge, so it is high for exactly the one cycle after the edge that sampled the last pattern bit.
REQ-017 Overlapping mode (overlap=1): on hit, fill advances normally, so a suffix of the match may begin the next match.
REQ-018 Non-overlapping mode (overlap=0): on hit, fill <= 0 while hist still shifts, so no bit of the match is reused.
REQ-019 overlap SHALL be sampled on the same edge as the hit; a change in overlap affects only subsequent matches.
REQ-020 en=0: hist, fill and match_cnt hold, and match <= 0.
REQ-021 clr=1 (priority over en): hist <= 0, fill <= 0, match <= 0, match_cnt <= 0; x is ignored on that edge.
REQ-022 On hit, match_cnt <= match_cnt+1, saturating at 2^CNT_W-1 with no wrap.
REQ-023 primed SHALL be combinational from fill (fill == PAT_LEN).

Reset
REQ-024 With rst=1, hist, fill, match and match_cnt SHALL go to 0 immediately, independent of clk; primed therefore reads 0.
REQ-025 Assertion of rst mid-pattern SHALL discard all partial progress; detection restarts from fill=0 on the first enabled edge after deassertion.

Configuration
REQ-026 Macro SEQ_DETECTOR_PARAM_COUNT_EN: when defined, the match counter is built as specified in REQ-022.
REQ-027 Without SEQ_DETECTOR_PARAM_COUNT_EN, no counter flops are built and match_cnt is tied to 0; all other behaviour is unchanged.

Verification (PAT_LEN=4, PATTERN=1011, CNT_W=8, COUNT_EN defined unless stated)
REQ-028 en=1, overlap=1, x=1,0,1,1,0,1,1 -> match pulses after edges 4 and 7; match_cnt=2.
REQ-029 Same stream with overlap=0 -> a single match after edge 4; match_cnt=1; fill=3 after edge 7.
REQ-030 x=1,0,1 with en=1, then en=0 for 3 cycles, then x=1 with en=1 -> match after the 4th enabled edge; no match during en=0.
REQ-031 clr=1 on the edge that would sample the final 1 of 1011 -> no match, match_cnt=0, fill=0; and rst pulsed mid-pattern -> outputs are 0 asynchronously.
REQ-032 CNT_W=2, overlap=1, five back-to-back 1011 matches -> match_cnt saturates at 3; match still pulses 5 times.
REQ-033 COUNT_EN undefined, same stimulus as REQ-028 -> identical match pulses; match_cnt=0 throughout.
